hex_display_bank: RTL and testbench
===================================

// Module: hex_display_bank
// PURPOSE
//   Parametrised N-digit hex display driver for the board HEX outputs; successor to the fixed 8-digit
//   display path. Accepts a packed hex value over a valid/ready handshake and runs a sequential
//   leading-zero-blanking scan. Commits atomically, so digits never show a half-updated value.
//   Adds per-digit blink. Used by the decoder to show MIDI note/velocity and debug state.
// PARAMETERS
//   NUM_DIGITS  8           number of 7-segment digits driven; >=1
//   BLINK_DIV   25_000_000  clock cycles per blink half-period; >=2
// PORTS
//   clock        in   1             system clock, all state on posedge
//   reset        in   1             asynchronous, active-high reset
//   value        in   4*NUM_DIGITS  packed nibbles, digit 0 = value[3:0] (rightmost)
//   value_valid  in   1             producer offers value
//   value_ready  out  1             block can accept; transfer when valid & ready at posedge
//   blank_lz_en  in   1             enable leading-zero blanking; sampled at transfer
//   blink_en     in   1             global blink enable, live
//   blink_mask   in   NUM_DIGITS    digits subject to blink, live
//   busy         out  1             scan/commit in progress (= ~value_ready)
//   segments     out  7*NUM_DIGITS  active-low segments, digit i = segments[7i+6:7i], bit6 = g
// BEHAVIOUR
//   Reset (async): FSM IDLE; shadow/display nibbles 0; display blank mask all 1s; blink counter 0;
//   blink phase 0; segments all 7'h7F (dark); value_ready reads 1 (decoded from IDLE).
//   FSM: IDLE -> SCAN -> COMMIT -> IDLE. value_ready = (state==IDLE).
//   IDLE: on valid & ready, capture value into shadow. Set idx=NUM_DIGITS-1, lz_active=blank_lz_en.
//     Go to SCAN.
//   SCAN: one digit per cycle, idx descending.
//     If lz_active & nibble==0 & idx!=0, then blank[idx]=1.
//     Otherwise blank[idx]=0 and lz_active=0.
//     At idx==0, go to COMMIT. Digit 0 is never LZ-blanked.
//   COMMIT: copy shadow nibbles and blank mask into display registers in one edge, then go to IDLE.
//   Latency: capture edge E0 -> COMMIT edge E(N+1) -> segments registered at E(N+2).
//     For NUM_DIGITS=8 this is 10 cycles.
//   valid while not ready: ignored, nothing captured; producer must hold value_valid until transfer.
//   Input value/blank_lz_en changes after capture have no effect on the scan in flight.
//   Display registers hold the previous image until COMMIT (no tearing).
//   Blink: the counter runs 0..BLINK_DIV-1 continuously; at wrap it resets to 0 and toggles phase.
//   Output register, every cycle, for each digit i:
//     seg[i] = (disp_blank[i] | (blink_en & phase & blink_mask[i])) ? 7'h7F : dec(disp_nibble[i]).
//     Changes to blink_en/blink_mask are visible one cycle later.
//   Decode (active-low, gfedcba):
//     0=100_0000 1=111_1001 2=010_0100 3=011_0000 4=001_1001 5=001_0010 6=000_0010 7=111_1000
//     8=000_0000 9=001_0000 A=000_1000 b=000_0011 C=100_0110 d=010_0001 E=000_0110 F=000_1110
//   Reset asserted mid-SCAN/COMMIT: abort immediately; display goes dark; the captured value is lost.
//   idx width = max(1,$clog2(NUM_DIGITS)). Blink counter width = $clog2(BLINK_DIV).
//     No counter overflow is possible.
// STRUCTURE
//   Package display_pkg: typedef enum logic [1:0] {IDLE, SCAN, COMMIT} disp_state_t;
//     localparam logic [6:0] SEG_BLANK = 7'h7F.
//   Sub-module hex_to_segment: combinational nibble -> 7-bit active-low decode,
//     instantiated NUM_DIGITS times via generate.
//   Top: FSM, shadow/display/blank registers, blink prescaler, registered segment outputs.
// TESTING
//   1 reset pulse mid-run -> segments all 7'h7F, value_ready=1, busy=0, state IDLE.
//   2 N=8, value=32'h0000_00A5, lz=1, 1-cycle valid -> ready low 9 cycles;
//     at +10: digits7..2=7F, d1=000_1000, d0=001_0010.
//   3 value=0, lz=1 -> only d0 lit = 100_0000. Same value with lz=0 -> all 8 digits = 100_0000.
//   4 value=32'h1234_5678, then valid held with 32'hFFFF_FFFF during scan -> second value not taken
//     until ready=1. First image shown intact, then all F=000_1110.
//   5 BLINK_DIV=4, blink_en=1, mask=8'h01, value=5 -> d0 alternates 001_0010 / 7F every 4 cycles,
//     other digits steady.
//   6 reset asserted at SCAN idx=3 -> segments 7F next cycle. After release, a new transfer
//     completes normally with 10-cycle latency.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the hex display bank.
// FSM state encoding and the dark segment pattern.
package display_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} disp_state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
endpackage

// File: rtl/hex_to_segment.sv
// Combinational nibble to active-low 7-segment decode.
// Bit order is gfedcba.
module hex_to_segment (
  input  logic [3:0] nibble,
  output logic [6:0] segments
);
  always_comb begin
    segments = 7'h7F;
    case (nibble)
      4'h0: segments = 7'b100_0000;
      4'h1: segments = 7'b111_1001;
      4'h2: segments = 7'b010_0100;
      4'h3: segments = 7'b011_0000;
      4'h4: segments = 7'b001_1001;
      4'h5: segments = 7'b001_0010;
      4'h6: segments = 7'b000_0010;
      4'h7: segments = 7'b111_1000;
      4'h8: segments = 7'b000_0000;
      4'h9: segments = 7'b001_0000;
      4'hA: segments = 7'b000_1000;
      4'hB: segments = 7'b000_0011;
      4'hC: segments = 7'b100_0110;
      4'hD: segments = 7'b010_0001;
      4'hE: segments = 7'b000_0110;
      4'hF: segments = 7'b000_1110;
      default: segments = 7'h7F;
    endcase
  end
endmodule

// File: rtl/hex_display_bank.sv
// N-digit hex display driver: handshake capture, sequential leading-zero scan,
// atomic commit to the display image, per-digit blink and registered segments.
module hex_display_bank
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic                    blank_lz_en,
  input  logic                    blink_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic                    busy,
  output logic [7*NUM_DIGITS-1:0] segments
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [IW-1:0] IDX_TOP = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  disp_state_t             state_reg, state_next;
  logic [IW-1:0]           idx_reg, idx_next;
  logic                    lz_reg, lz_next;
  logic [4*NUM_DIGITS-1:0] shadow_reg, shadow_next;
  logic [NUM_DIGITS-1:0]   blank_scan_reg, blank_scan_next;
  logic [4*NUM_DIGITS-1:0] disp_nibble_reg;
  logic [NUM_DIGITS-1:0]   disp_blank_reg;
  logic [CW-1:0]           blink_cnt_reg;
  logic                    phase_reg;
  logic [7*NUM_DIGITS-1:0] seg_reg, seg_next, dec_seg;
  logic                    commit;
  logic [3:0]              scan_nibble;

  assign value_ready = (state_reg == IDLE);
  assign busy        = ~value_ready;
  assign segments    = seg_reg;

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    lz_next         = lz_reg;
    shadow_next     = shadow_reg;
    blank_scan_next = blank_scan_reg;
    commit          = 1'b0;
    scan_nibble     = shadow_reg[idx_reg*4 +: 4];
    case (state_reg)
      IDLE: begin
        if (value_valid) begin
          shadow_next = value;
          idx_next    = IDX_TOP;
          lz_next     = blank_lz_en;
          state_next  = SCAN;
        end
      end
      SCAN: begin
        // Blanking stops at the first non-zero nibble; digit 0 always shows.
        if (lz_reg && scan_nibble == 4'h0 && idx_reg != '0) begin
          blank_scan_next[idx_reg] = 1'b1;
        end else begin
          blank_scan_next[idx_reg] = 1'b0;
          lz_next = 1'b0;
        end
        if (idx_reg == '0) state_next = COMMIT;
        else               idx_next   = idx_reg - IW'(1);
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      hex_to_segment u_dec (
        .nibble   (disp_nibble_reg[gi*4 +: 4]),
        .segments (dec_seg[gi*7 +: 7])
      );
      assign seg_next[gi*7 +: 7] =
        (disp_blank_reg[gi] | (blink_en & phase_reg & blink_mask[gi])) ? SEG_BLANK : dec_seg[gi*7 +: 7];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      lz_reg          <= 1'b0;
      shadow_reg      <= '0;
      blank_scan_reg  <= '1;
      disp_nibble_reg <= '0;
      disp_blank_reg  <= '1;
      blink_cnt_reg   <= '0;
      phase_reg       <= 1'b0;
      seg_reg         <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      lz_reg         <= lz_next;
      shadow_reg     <= shadow_next;
      blank_scan_reg <= blank_scan_next;
      if (commit) begin
        disp_nibble_reg <= shadow_reg;
        disp_blank_reg  <= blank_scan_reg;
      end
      if (blink_cnt_reg == CNT_MAX) begin
        blink_cnt_reg <= '0;
        phase_reg     <= ~phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + CW'(1);
      end
      seg_reg <= seg_next;
    end
  end
endmodule

// File: tb/tb_hex_display_bank.sv
// Self-checking bench for hex_display_bank: vector table through a scoreboard
// queue, plus held-valid, blink and mid-scan reset sequences.
module tb_hex_display_bank;
  import display_pkg::*;

  localparam int N  = 8;
  localparam int BD = 4;
  localparam logic [55:0] DARK = {8{7'h7F}};

  logic          clock, reset;
  logic [31:0]   value;
  logic          value_valid, value_ready, blank_lz_en, blink_en, busy;
  logic [N-1:0]  blink_mask;
  logic [7*N-1:0] segments;

  int checks = 0;
  int errors = 0;
  logic [55:0] exp_q[$];

  typedef struct {
    logic [31:0] v;
    logic        lz;
    logic [55:0] exp;
  } vec_t;
  vec_t vecs[8];

  hex_display_bank #(.NUM_DIGITS(N), .BLINK_DIV(BD)) dut (
    .clock       (clock),
    .reset       (reset),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .blank_lz_en (blank_lz_en),
    .blink_en    (blink_en),
    .blink_mask  (blink_mask),
    .busy        (busy),
    .segments    (segments)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic send(input logic [31:0] v, input logic lz, input logic [55:0] e);
    int n;
    n = 0;
    @(negedge clock);
    while (!value_ready && n < 100) begin
      n++;
      @(negedge clock);
    end
    if (n >= 100) check("send_ready_timeout", 64'(value_ready), 64'd1);
    value       = v;
    blank_lz_en = lz;
    value_valid = 1'b1;
    exp_q.push_back(e);
    @(negedge clock);
    value_valid = 1'b0;
    // Scribble the inputs so a scan that re-reads them shows up.
    value       = $urandom;
    blank_lz_en = ~lz;
  endtask

  task automatic wait_result(input string name, input logic [55:0] prev);
    int n, tear;
    logic [55:0] e;
    n = 0;
    tear = 0;
    while (!value_ready && n < 50) begin
      if (segments !== prev) tear++;
      n++;
      @(negedge clock);
    end
    check({name, "_busy_cycles"}, 64'(n), 64'd9);
    check({name, "_no_tear"}, 64'(tear), 64'd0);
    @(negedge clock);
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, "_segments"}, 64'(segments), 64'(e));
    end
  endtask

  initial begin
    logic [55:0] prev;
    logic [6:0]  s[30];
    int          k, bad, bad1, n;

    vecs[0] = '{32'h0000_00A5, 1'b1, {{6{7'h7F}}, 7'h08, 7'h12}};
    vecs[1] = '{32'h0000_0000, 1'b1, {{7{7'h7F}}, 7'h40}};
    vecs[2] = '{32'h0000_0000, 1'b0, {8{7'h40}}};
    vecs[3] = '{32'h1234_5678, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}};
    vecs[4] = '{32'h0001_0000, 1'b1, {{3{7'h7F}}, 7'h79, {4{7'h40}}}};
    vecs[5] = '{32'h0000_00A5, 1'b0, {{6{7'h40}}, 7'h08, 7'h12}};
    vecs[6] = '{32'hFEDC_BA90, 1'b1, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h40}};
    vecs[7] = '{32'h0000_0001, 1'b1, {{7{7'h7F}}, 7'h79}};

    reset = 1'b1; value = '0; value_valid = 1'b0; blank_lz_en = 1'b0;
    blink_en = 1'b0; blink_mask = '0;
    repeat (3) @(negedge clock);
    check("reset_segments", 64'(segments), 64'(DARK));
    check("reset_ready", 64'(value_ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    prev = DARK;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].v, vecs[i].lz, vecs[i].exp);
      wait_result($sformatf("vec%0d", i), prev);
      prev = vecs[i].exp;
    end

    // Reset pulse while an image is shown.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrun_reset_segments", 64'(segments), 64'(DARK));
    check("midrun_reset_ready", 64'(value_ready), 64'd1);
    check("midrun_reset_busy", 64'(busy), 64'd0);
    check("midrun_reset_state", 64'(dut.state_reg), 64'(IDLE));
    reset = 1'b0;
    prev = DARK;

    // Valid held with a second value through the first scan.
    send(32'h1234_5678, 1'b1, vecs[3].exp);
    value = 32'hFFFF_FFFF;
    blank_lz_en = 1'b1;
    value_valid = 1'b1;
    exp_q.push_back({8{7'h0E}});
    n = 0; bad = 0;
    while (!value_ready && n < 50) begin
      if (segments !== prev) bad++;
      n++;
      @(negedge clock);
    end
    check("held_first_busy_cycles", 64'(n), 64'd9);
    check("held_first_no_tear", 64'(bad), 64'd0);
    @(negedge clock);
    value_valid = 1'b0;
    check("held_second_taken", 64'(value_ready), 64'd0);
    check("held_first_segments", 64'(segments), 64'(exp_q.pop_front()));
    prev = vecs[3].exp;
    n = 0; bad = 0;
    while (!value_ready && n < 50) begin
      if (segments !== prev) bad++;
      n++;
      @(negedge clock);
    end
    check("held_second_busy_cycles", 64'(n), 64'd9);
    check("held_second_no_tear", 64'(bad), 64'd0);
    @(negedge clock);
    check("held_second_segments", 64'(segments), 64'(exp_q.pop_front()));
    prev = {8{7'h0E}};

    // Blink on digit 0 only.
    send(32'h0000_0005, 1'b0, {{7{7'h40}}, 7'h12});
    wait_result("blink_load", prev);
    blink_mask = 8'h01;
    blink_en   = 1'b1;
    @(negedge clock);
    bad1 = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clock);
      s[j] = segments[6:0];
      if (segments[55:7] !== {7{7'h40}}) bad1++;
    end
    check("blink_others_steady", 64'(bad1), 64'd0);
    k = 0;
    for (int j = 1; j < 9; j++) if (k == 0 && s[j] !== s[j-1]) k = j;
    check("blink_toggle_found", 64'(k != 0), 64'd1);
    if (k == 0) k = 1;
    check("blink_levels", 64'(s[k] ^ s[k-1]), 64'(7'h12 ^ 7'h7F));
    bad = 0;
    for (int j = k; j < k + 20; j++) begin
      if (s[j] !== ((((j - k) / 4) % 2 == 0) ? s[k] : s[k-1])) bad++;
    end
    check("blink_period", 64'(bad), 64'd0);
    blink_en = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("blink_off_digit0", 64'(segments[6:0]), 64'(7'h12));
    blink_mask = '0;
    prev = {{7{7'h40}}, 7'h12};

    // Reset asserted while the scan is at digit 3.
    send(32'h0000_00A5, 1'b1, vecs[0].exp);
    repeat (4) @(negedge clock);
    check("abort_at_idx3", 64'(dut.idx_reg), 64'd3);
    reset = 1'b1;
    @(negedge clock);
    check("abort_segments", 64'(segments), 64'(DARK));
    check("abort_ready", 64'(value_ready), 64'd1);
    exp_q.delete();
    reset = 1'b0;
    send(32'h1234_5678, 1'b1, vecs[3].exp);
    wait_result("after_abort", DARK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
